// File: rtl/flex_cnt_pkg.sv
// Shared types and next-count arithmetic for flex_counter_multimode.
package flex_cnt_pkg;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_t;

    // Arithmetic is done at a fixed width; counters up to 32 bits are supported.
    localparam int unsigned CALC_W        = 32;
    localparam int unsigned DOWN_TERMINAL = 1;

    function automatic logic [CALC_W-1:0] next_count(
        input logic [CALC_W-1:0] count,
        input logic [CALC_W-1:0] rollover,
        input cnt_dir_t          dir
    );
        logic [CALC_W-1:0] nxt;
        nxt = count;
        if (dir == CNT_UP) begin
            nxt = (count >= rollover) ? CALC_W'(1) : count + CALC_W'(1);
        end else begin
            nxt = (count <= CALC_W'(DOWN_TERMINAL)) ? rollover : count - CALC_W'(1);
        end
        return nxt;
    endfunction

    // Down from 0 is a reload, so only count==1 wraps in down mode.
    function automatic logic is_wrap(
        input logic [CALC_W-1:0] count,
        input logic [CALC_W-1:0] rollover,
        input cnt_dir_t          dir
    );
        logic w;
        if (dir == CNT_UP) begin
            w = (count >= rollover);
        end else begin
            w = (count == CALC_W'(DOWN_TERMINAL));
        end
        return w;
    endfunction

endpackage

// File: rtl/flex_counter_multimode_prescaler.sv
// Enable prescaler: step_en fires on every PRESCALE_DIV-th enabled cycle.
module flex_prescaler #(
    parameter int unsigned PRESCALE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_en,
    output logic step_en
);

    localparam int unsigned CNT_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;

    assign step_en = in_en && (div_cnt == CNT_W'(PRESCALE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (in_en) begin
            div_cnt <= step_en ? '0 : div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/flex_counter_multimode.sv
// Multimode up/down counter with load, one-shot, wrap pulse and saturating wrap tally.
// Optional enable prescaler is built when FLEX_CNT_PRESCALE_EN is defined.
module flex_counter_multimode
    import flex_cnt_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = 9,
    parameter int unsigned WRAP_BITS    = 4,
    parameter int unsigned PRESCALE_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    dir,
    input  logic                    one_shot,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    rollover_pulse,
    output logic                    done,
    output logic [WRAP_BITS-1:0]    wrap_cnt
);

    cnt_dir_t                dir_s;
    logic                    step_en;
    logic                    done_eff;
    logic                    wrap_evt;
    logic [NUM_CNT_BITS-1:0] term;
    logic [NUM_CNT_BITS-1:0] load_clamped;
    logic [NUM_CNT_BITS-1:0] count_nxt;
    logic                    flag_nxt;
    logic                    pulse_nxt;
    logic                    done_nxt;
    logic [WRAP_BITS-1:0]    wrap_nxt;

    assign dir_s = cnt_dir_t'(dir);

`ifdef FLEX_CNT_PRESCALE_EN
    flex_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear | load),
        .in_en  (count_enable),
        .step_en(step_en)
    );
`else
    logic [7:0] unused_prescale_div;
    assign unused_prescale_div = 8'(PRESCALE_DIV);
    assign step_en             = count_enable;
`endif

    // Dropping one_shot releases a held terminal in the same cycle.
    assign done_eff     = done & one_shot;
    assign term         = (dir_s == CNT_DOWN) ? NUM_CNT_BITS'(DOWN_TERMINAL) : rollover_val;
    assign load_clamped = (load_val < rollover_val) ? load_val : rollover_val;
    assign wrap_evt     = is_wrap(CALC_W'(count_out), CALC_W'(rollover_val), dir_s);

    always_comb begin
        count_nxt = count_out;
        flag_nxt  = rollover_flag;
        pulse_nxt = 1'b0;
        done_nxt  = done_eff;
        wrap_nxt  = wrap_cnt;
        if (clear) begin
            count_nxt = '0;
            flag_nxt  = 1'b0;
            done_nxt  = 1'b0;
            wrap_nxt  = '0;
        end else if (load) begin
            count_nxt = load_clamped;
            flag_nxt  = (rollover_val != '0) && (load_clamped == term);
            done_nxt  = 1'b0;
        end else if (step_en) begin
            if (rollover_val == '0) begin
                flag_nxt = 1'b0;
            end else if (!done_eff) begin
                count_nxt = NUM_CNT_BITS'(next_count(CALC_W'(count_out), CALC_W'(rollover_val), dir_s));
                flag_nxt  = (count_nxt == term);
                if (one_shot && (count_nxt == term)) begin
                    done_nxt = 1'b1;
                end
                if (wrap_evt) begin
                    pulse_nxt = 1'b1;
                    if (wrap_cnt != {WRAP_BITS{1'b1}}) begin
                        wrap_nxt = wrap_cnt + WRAP_BITS'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            done           <= 1'b0;
            wrap_cnt       <= '0;
        end else begin
            count_out      <= count_nxt;
            rollover_flag  <= flag_nxt;
            rollover_pulse <= pulse_nxt;
            done           <= done_nxt;
            wrap_cnt       <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_flex_counter_multimode.sv
// Randomized and directed checks of flex_counter_multimode against a behavioural model.
module tb_flex_counter_multimode;

    localparam int unsigned NB   = 9;
    localparam int unsigned WB   = 2;
    localparam int unsigned DIV  = 4;
    localparam int          WMAX = (1 << WB) - 1;
`ifdef FLEX_CNT_PRESCALE_EN
    localparam int STEP    = DIV;
    localparam int AFTER9  = 2;
`else
    localparam int STEP    = 1;
    localparam int AFTER9  = 9;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          load;
    logic [NB-1:0] load_val;
    logic          count_enable;
    logic          dir;
    logic          one_shot;
    logic [NB-1:0] rollover_val;
    logic [NB-1:0] count_out;
    logic          rollover_flag;
    logic          rollover_pulse;
    logic          done;
    logic [WB-1:0] wrap_cnt;

    int total = 0;
    int bad   = 0;

    int m_cnt, m_flag, m_pulse, m_done, m_wraps, m_pre;

    flex_counter_multimode #(
        .NUM_CNT_BITS(NB),
        .WRAP_BITS   (WB),
        .PRESCALE_DIV(DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .load          (load),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .dir           (dir),
        .one_shot      (one_shot),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .rollover_pulse(rollover_pulse),
        .done          (done),
        .wrap_cnt      (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_flag = 0; m_pulse = 0; m_done = 0; m_wraps = 0; m_pre = 0;
    endtask

    // Next expected state from the currently applied inputs.
    task automatic model_step();
        int rv;
        int term;
        bit step;
        bit wrap;
        rv   = int'(rollover_val);
        term = dir ? 1 : rv;
        if (clear) begin
            model_reset();
        end else if (load) begin
            m_cnt   = (int'(load_val) < rv) ? int'(load_val) : rv;
            m_flag  = (rv != 0 && m_cnt == term) ? 1 : 0;
            m_done  = 0;
            m_pulse = 0;
            m_pre   = 0;
        end else begin
            m_pulse = 0;
            if (!one_shot) m_done = 0;
            step = count_enable;
`ifdef FLEX_CNT_PRESCALE_EN
            if (count_enable) begin
                m_pre++;
                step = (m_pre == DIV);
                if (step) m_pre = 0;
            end
`endif
            if (step && rv == 0) begin
                m_flag = 0;
            end else if (step && m_done == 0) begin
                if (dir) begin
                    wrap  = (m_cnt == 1);
                    m_cnt = (m_cnt <= 1) ? rv : m_cnt - 1;
                end else begin
                    wrap  = (m_cnt >= rv);
                    m_cnt = wrap ? 1 : m_cnt + 1;
                end
                if (wrap) begin
                    m_pulse = 1;
                    if (m_wraps < WMAX) m_wraps++;
                end
                m_flag = (m_cnt == term) ? 1 : 0;
                if (one_shot && m_flag != 0) m_done = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, int'(count_out), m_cnt);
        chk({tag, ".flag"},  int'(rollover_flag), m_flag);
        chk({tag, ".pulse"}, int'(rollover_pulse), m_pulse);
        chk({tag, ".done"},  int'(done), m_done);
        chk({tag, ".wraps"}, int'(wrap_cnt), m_wraps);
    endtask

    // One clock with the current inputs; outputs checked on the falling edge.
    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic set_in(input bit c, input bit l, input int lv, input bit en,
                          input bit d, input bit os, input int rv);
        clear        = c;
        load         = l;
        load_val     = NB'(lv);
        count_enable = en;
        dir          = d;
        one_shot     = os;
        rollover_val = NB'(rv);
    endtask

    int seq2[7] = '{1, 2, 3, 1, 2, 3, 1};
    int pul2[7] = '{0, 0, 0, 1, 0, 0, 1};
    int seq3[4] = '{3, 2, 1, 4};
    int seq4[5] = '{1, 2, 2, 2, 2};

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 9);
        model_reset();
        #2;
        check_model("por");
        @(negedge clk);
        rst = 1'b0;

        // 1: async reset mid-count
        set_in(1, 0, 0, 0, 0, 0, 9); cyc("t1clr");
        set_in(0, 0, 0, 1, 0, 0, 9);
        repeat (5 * STEP) cyc("t1run");
        chk("t1.pre_rst_count", int'(count_out), 5);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model("t1.async");
        @(negedge clk);
        rst = 1'b0;

        // 2: up count, rollover 3
        set_in(1, 0, 0, 0, 0, 0, 3); cyc("t2clr");
        set_in(0, 0, 0, 1, 0, 0, 3);
        for (int k = 0; k < 7; k++) begin
            repeat (STEP) cyc("t2run");
            chk("t2.count", int'(count_out), seq2[k]);
            chk("t2.pulse", int'(rollover_pulse), pul2[k]);
            chk("t2.flag", int'(rollover_flag), (seq2[k] == 3) ? 1 : 0);
        end
        chk("t2.wraps", int'(wrap_cnt), 2);

        // 3: down count after clamped load
        set_in(0, 1, 9, 0, 1, 0, 4); cyc("t3ld");
        chk("t3.clamp", int'(count_out), 4);
        set_in(0, 0, 0, 1, 1, 0, 4);
        for (int k = 0; k < 4; k++) begin
            repeat (STEP) cyc("t3run");
            chk("t3.count", int'(count_out), seq3[k]);
        end
        chk("t3.pulse", int'(rollover_pulse), 1);

        // 4: one-shot stop at terminal
        set_in(1, 0, 0, 0, 0, 1, 2); cyc("t4clr");
        set_in(0, 0, 0, 1, 0, 1, 2);
        for (int k = 0; k < 5; k++) begin
            repeat (STEP) cyc("t4run");
            chk("t4.count", int'(count_out), seq4[k]);
            chk("t4.done", int'(done), (k >= 1) ? 1 : 0);
        end
        set_in(0, 1, 0, 0, 0, 1, 2); cyc("t4ld");
        chk("t4.rel_done", int'(done), 0);
        chk("t4.rel_count", int'(count_out), 0);

        // 5: clear beats load; tally saturation
        set_in(0, 0, 0, 1, 0, 0, 1);
        repeat (3 * STEP) cyc("t5pre");
        set_in(1, 1, 5, 1, 0, 0, 1); cyc("t5both");
        chk("t5.clr_count", int'(count_out), 0);
        chk("t5.clr_wraps", int'(wrap_cnt), 0);
        set_in(0, 0, 0, 1, 0, 0, 1);
        repeat (6 * STEP) cyc("t5sat");
        chk("t5.sat", int'(wrap_cnt), 3);

        // 6: prescaler / raw enable comparison
        set_in(1, 0, 0, 0, 0, 0, 9); cyc("t6clr");
        set_in(0, 0, 0, 1, 0, 0, 9);
        repeat (9) cyc("t6run");
        chk("t6.after9", int'(count_out), AFTER9);
        repeat (3) cyc("t6run");
        chk("t6.after12", int'(count_out), 3);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            int rv;
            case ($urandom_range(0, 9))
                0:       rv = 0;
                1:       rv = int'($urandom_range(0, (1 << NB) - 1));
                2:       rv = (1 << NB) - 1;
                default: rv = int'($urandom_range(1, 6));
            endcase
            if ($urandom_range(0, 7) != 0) rv = int'(rollover_val);
            set_in(($urandom_range(0, 49) == 0),
                   ($urandom_range(0, 24) == 0),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, (1 << NB) - 1)),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 19) == 0) ? ~dir : dir,
                   ($urandom_range(0, 29) == 0) ? ~one_shot : one_shot,
                   rv);
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
